idct_transpose: RTL and testbench

- Ping-pong transpose buffer between the row IDCT stage and the column IDCT stage.
- Accepts row-stage results one sample per cycle in row-major order and stores a complete 4x4 or 8x8 block.
- Replays the block column-major as a gap-free serial stream, with the block-size code aligned to each sample, which is the input format the column stage expects.
- Two banks, so one block can be written while the previous one is read.

---
 rtl/idct_transpose.sv | 148 ++++++++++++++
 tb/tb_idct_transpose.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idct_transpose.sv
// Ping-pong 4x4/8x8 transpose buffer: row-major samples in, column-major stream out.
// Optional macro TRANSPOSE_CLIP_EN: saturate din to WIDTH_X instead of wrapping.
module idct_transpose #(
  parameter int WIDTH_IN = 18,
  parameter int WIDTH_X  = 16,
  parameter int N_MAX    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [WIDTH_IN-1:0] din,
  input  logic                       din_valid,
  input  logic [1:0]                 din_size,
  output logic                       din_ready,
  output logic signed [WIDTH_X-1:0]  x,
  output logic [1:0]                 idct4,
  output logic                       x_valid
);

  localparam int DEPTH = N_MAX * N_MAX;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [1:0]    SZ4   = 2'b01;
  localparam logic [1:0]    SZ8   = 2'b10;
  localparam logic [AW-1:0] LAST4 = AW'(15);
  localparam logic [AW-1:0] LAST8 = AW'(63);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} rd_state_t;

  // Handshake: a sample transfers on a clk edge where din_valid && din_ready.
  // rd_state is left as a named internal signal so checkers can bind to it.
  rd_state_t         rd_state;
  logic [WIDTH_X-1:0] mem [0:2*DEPTH-1];
  logic [1:0]        full;
  logic [1:0]        size_tag [0:1];
  logic              wr_bank, rd_bank;
  logic [AW-1:0]     wr_cnt, rd_cnt;
  logic [1:0]        wr_size;

  logic [1:0]         wr_size_eff, rd_size;
  logic [AW-1:0]      wr_addr, rd_addr;
  logic               wr_fire, wr_last, rd_last, other_full;
  logic [WIDTH_X-1:0] din_n;

  assign din_ready = !full[wr_bank];

`ifdef TRANSPOSE_CLIP_EN
  logic [WIDTH_IN-WIDTH_X:0] din_hi;
  assign din_hi = din[WIDTH_IN-1:WIDTH_X-1];
  always_comb begin
    din_n = din[WIDTH_X-1:0];
    if (!(din_hi == '0 || din_hi == '1))
      din_n = din[WIDTH_IN-1] ? {1'b1, {(WIDTH_X-1){1'b0}}} : {1'b0, {(WIDTH_X-1){1'b1}}};
  end
`else
  logic unused_din_hi;
  assign unused_din_hi = ^din[WIDTH_IN-1:WIDTH_X];
  assign din_n = din[WIDTH_X-1:0];
`endif

  // The size code is only taken from din_size on the first sample of a block.
  always_comb begin
    wr_size_eff = (wr_cnt == '0) ? din_size : wr_size;
    wr_fire     = din_valid && din_ready &&
                  (wr_cnt != '0 || din_size == SZ4 || din_size == SZ8);
    if (wr_size_eff == SZ4) begin
      wr_addr = AW'(wr_cnt[3:2] * N_MAX + wr_cnt[1:0]);
      wr_last = wr_fire && (wr_cnt == LAST4);
    end else begin
      wr_addr = AW'(wr_cnt[5:3] * N_MAX + wr_cnt[2:0]);
      wr_last = wr_fire && (wr_cnt == LAST8);
    end
  end

  // Column-major walk: rd_cnt%N selects the row, rd_cnt/N the column.
  always_comb begin
    rd_size = size_tag[rd_bank];
    if (rd_size == SZ4) begin
      rd_addr = AW'(rd_cnt[1:0] * N_MAX + rd_cnt[3:2]);
      rd_last = (rd_cnt == LAST4);
    end else begin
      rd_addr = AW'(rd_cnt[2:0] * N_MAX + rd_cnt[5:3]);
      rd_last = (rd_cnt == LAST8);
    end
    // A block completing this same edge counts as ready, keeping the stream gap-free.
    other_full = full[~rd_bank] || wr_last;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank, wr_addr}] <= din_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full        <= 2'b00;
      size_tag[0] <= 2'b00;
      size_tag[1] <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wr_size     <= 2'b00;
      rd_state    <= IDLE;
      x           <= '0;
      idct4       <= 2'b00;
      x_valid     <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) begin
          wr_size           <= din_size;
          size_tag[wr_bank] <= din_size;
        end
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end

      case (rd_state)
        IDLE: begin
          x       <= '0;
          idct4   <= 2'b00;
          x_valid <= 1'b0;
          if (full[rd_bank]) begin
            rd_state <= STREAM;
            rd_cnt   <= '0;
          end
        end
        STREAM: begin
          x       <= mem[{rd_bank, rd_addr}];
          idct4   <= rd_size;
          x_valid <= 1'b1;
          if (rd_last) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            rd_cnt        <= '0;
            if (!other_full) rd_state <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: rd_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct_transpose.sv
// Self-checking bench for idct_transpose: scoreboard of transposed samples plus
// latency, contiguity, back-pressure and reset checks.
module tb_idct_transpose;

  localparam int WIDTH_IN = 18;
  localparam int WIDTH_X  = 16;
  localparam int N_MAX    = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic signed [WIDTH_IN-1:0] din;
  logic                       din_valid;
  logic [1:0]                 din_size;
  logic                       din_ready;
  logic signed [WIDTH_X-1:0]  x;
  logic [1:0]                 idct4;
  logic                       x_valid;

  idct_transpose #(.WIDTH_IN(WIDTH_IN), .WIDTH_X(WIDTH_X), .N_MAX(N_MAX)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_size(din_size),
    .din_ready(din_ready), .x(x), .idct4(idct4), .x_valid(x_valid)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH_X-1:0] narrow(input logic [WIDTH_IN-1:0] v);
`ifdef TRANSPOSE_CLIP_EN
    if ($signed(v) > 32767) return 16'h7FFF;
    if ($signed(v) < -32768) return 16'h8000;
`endif
    return v[WIDTH_X-1:0];
  endfunction

  // scoreboard: {idct4, x} in expected output order
  logic [WIDTH_X+1:0]  exp_q[$];
  logic [WIDTH_IN-1:0] blk [64];

  task automatic push_block(input logic [1:0] size, input int n);
    for (int j = 0; j < n; j++)
      for (int i = 0; i < n; i++)
        exp_q.push_back({size, narrow(blk[i*n+j])});
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n*n; i++) blk[i] = WIDTH_IN'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) blk[i] = WIDTH_IN'($urandom_range(0, 262143));
  endtask

  // monitor
  bit                 mon_en = 0;
  bit                 prev_valid = 0;
  int                 run = 0, last_run = 0, rise_edge = 0, edge64 = 0;
  logic [WIDTH_X+1:0] mon_e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (x_valid) begin
        if (!prev_valid) rise_edge = cyc;
        run++;
        if (run == 64) edge64 = cyc;
        if (exp_q.size() == 0) check("unexpected_x", 32'd1, 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("x_data", 32'({idct4, x}), 32'(mon_e));
        end
      end else begin
        check("idle_out", 32'({idct4, x}), 32'd0);
        if (prev_valid) begin
          last_run = run;
          run = 0;
        end
      end
      prev_valid = x_valid;
    end
  end

  // driver
  int last_xfer_edge = 0, xfer_total = 0, stalls = 0, stall_at = -1, ready_rise_edge = 0;
  bit was_stalled = 0;

  task automatic send_block(input logic [1:0] size, input int n, input bit gaps, input int limit);
    int  k = 0;
    int  budget = 0;
    bit  idle_slot = 0;
    while (k < limit) begin
      @(negedge clk);
      budget++;
      if (budget > 4000) begin
        check("send_timeout", 32'd0, 32'd1);
        break;
      end
      if (gaps && idle_slot) begin
        din_valid = 1'b0;
        din       = WIDTH_IN'($urandom);
        din_size  = 2'($urandom_range(0, 3));
        idle_slot = 0;
      end else begin
        din_valid = 1'b1;
        din       = blk[k];
        din_size  = (k == 0) ? size : 2'($urandom_range(0, 3));
        if (din_ready) begin
          if (was_stalled) begin
            ready_rise_edge = cyc;
            was_stalled = 0;
          end
          k++;
          xfer_total++;
          last_xfer_edge = cyc + 1;
          idle_slot = 1;
          if (k == n*n) push_block(size, n);
        end else begin
          if (stalls == 0) stall_at = xfer_total;
          stalls++;
          was_stalled = 1;
        end
      end
    end
  endtask

  task automatic send_bad(input logic [1:0] sz);
    @(negedge clk);
    din_valid = 1'b1;
    din_size  = sz;
    din       = WIDTH_IN'(18'h00ABC);
    check("bad_ready", 32'(din_ready), 32'd1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    din_valid = 1'b0;
    din_size  = 2'b00;
    din       = '0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || x_valid) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; din_valid = 1'b0; din = '0; din_size = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_idct4", 32'(idct4), 32'd0);
    check("rst_x_valid", 32'(x_valid), 32'd0);
    check("rst_din_ready", 32'(din_ready), 32'd1);

    // 8x8 ramp
    fill_ramp(8);
    send_block(2'b10, 8, 0, 64);
    go_idle();
    drain();
    check("t1_run", 32'(last_run), 32'd64);
    check("t1_latency", 32'(rise_edge - last_xfer_edge), 32'd2);

    // 4x4 ramp
    fill_ramp(4);
    send_block(2'b01, 4, 0, 16);
    go_idle();
    drain();
    check("t2_run", 32'(last_run), 32'd16);
    check("t2_latency", 32'(rise_edge - last_xfer_edge), 32'd2);

    // three back-to-back 8x8 blocks
    xfer_total = 0; stalls = 0; stall_at = -1;
    for (int b = 0; b < 3; b++) begin
      fill_rand();
      send_block(2'b10, 8, 0, 64);
    end
    go_idle();
    drain();
    check("t3_run", 32'(last_run), 32'd192);
    check("t3_stalls", 32'(stalls), 32'd1);
    check("t3_stall_at", 32'(stall_at), 32'd128);
    check("t3_ready_rise", 32'(ready_rise_edge), 32'(edge64));

    // saturation / wrap corners
    fill_rand();
    blk[0] = 18'h1FFFF;
    blk[1] = 18'h20000;
    blk[9] = 18'h08000;
    blk[10] = 18'h37FFF;
    send_block(2'b10, 8, 0, 64);
    go_idle();
    drain();
    check("t4_run", 32'(last_run), 32'd64);

    // reset during a partial block, then a fresh 4x4
    fill_rand();
    send_block(2'b10, 8, 0, 30);
    @(negedge clk);
    din_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_ready", 32'(din_ready), 32'd1);
    check("t5_x_valid", 32'(x_valid), 32'd0);
    fill_rand();
    send_block(2'b01, 4, 0, 16);
    go_idle();
    drain();
    check("t5_run", 32'(last_run), 32'd16);
    check("t5_latency", 32'(rise_edge - last_xfer_edge), 32'd2);

    // invalid first sizes dropped, then 8x8 with alternating valid gaps
    send_bad(2'b00);
    send_bad(2'b11);
    fill_rand();
    send_block(2'b10, 8, 1, 64);
    go_idle();
    drain();
    check("t6_run", 32'(last_run), 32'd64);
    check("t6_latency", 32'(rise_edge - last_xfer_edge), 32'd2);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
